// File: rtl/data_memory_pkg.sv
// ============================================================================
// Module : dm_pkg
// Brief  : Shared constants and word/address types for the data memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_pkg;

  localparam int DM_ADDR_W = 11;
  localparam int DM_DATA_W = 32;
  localparam int DM_DEPTH  = 2048;

  typedef logic [DM_ADDR_W-1:0] dm_addr_t;
  typedef logic [DM_DATA_W-1:0] dm_word_t;

endpackage : dm_pkg

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module : data_memory
// Brief  : Word-addressed data memory for the load/store path. Writes land on
//          the rising clock edge; reads are combinational. An asynchronous
//          active-high reset clears every word and forces the read port to 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Full address range is decoded: upper half is distinct storage, no aliasing.
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage update: reset clears the whole array and blocks any write pending
  // in the same cycle; otherwise a single word is written per enabled edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_mem_write) begin
      mem[i_addr] <= i_data;
    end
  end

  // Read mux: zero-latency lookup, held at zero while reset is asserted so the
  // output is clean even in the instant before the array clear is visible.
  always_comb begin
    o_data = '0;
    if (!i_rst) begin
      o_data = mem[i_addr];
    end
  end

endmodule : data_memory

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module : tb_data_memory
// Brief  : Self-checking bench for data_memory. Expected read values are
//          queued when a read address is driven and popped for comparison
//          once the combinational output has settled.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;
  import dm_pkg::*;

  logic     clk;
  logic     rst;
  logic     mem_write;
  dm_addr_t addr;
  dm_word_t wdata;
  dm_word_t rdata;

  int total = 0;
  int bad   = 0;

  dm_word_t sb[$];
  dm_word_t model [DM_DEPTH];

  data_memory #(
    .ADDR_W (DM_ADDR_W),
    .DATA_W (DM_DATA_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mem_write (mem_write),
    .i_addr      (addr),
    .i_data      (wdata),
    .o_data      (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a read address and queue the value the bench expects to see.
  task automatic push_read(input dm_addr_t a, input dm_word_t e);
    addr = a;
    sb.push_back(e);
  endtask

  // One-edge write; the reference model follows the same edge.
  task automatic do_write(input dm_addr_t a, input dm_word_t d);
    @(negedge clk);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    @(posedge clk);
    model[a]  = d;
    #1;
    mem_write = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DM_DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    dm_word_t exp;
    dm_addr_t list [4];
    list = '{11'd0, 11'd1, 11'd1027, 11'd2047};
    rst = 1'b1; mem_write = 1'b0; addr = '0; wdata = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    push_read(11'd5, 32'h0);
    #1;
    exp = sb.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL reset_during got=%h exp=%h", rdata, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    foreach (list[i]) begin
      @(negedge clk);
      push_read(list[i], model[list[i]]);
      #1;
      exp = sb.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", list[i], rdata, exp);
      end
    end
  endtask

  task automatic test_write_low();
    dm_word_t exp;
    dm_addr_t list [2];
    do_write(11'd0, 32'hA5A5A5A5);
    do_write(11'd1, 32'h5A5A5A5A);
    list = '{11'd0, 11'd1};
    foreach (list[i]) begin
      @(negedge clk);
      push_read(list[i], model[list[i]]);
      #1;
      exp = sb.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL write_low addr=%0d got=%h exp=%h", list[i], rdata, exp);
      end
    end
  endtask

  task automatic test_high_addr();
    dm_word_t exp;
    dm_addr_t list [5];
    do_write(11'd1027, 32'hDEADBEEF);
    do_write(11'd2047, 32'h12345678);
    list = '{11'd1027, 11'd3, 11'd2047, 11'd1023, 11'd0};
    foreach (list[i]) begin
      @(negedge clk);
      push_read(list[i], model[list[i]]);
      #1;
      exp = sb.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL high_addr addr=%0d got=%h exp=%h", list[i], rdata, exp);
      end
    end
  endtask

  task automatic test_write_disable();
    dm_word_t exp;
    @(negedge clk);
    addr = 11'd0; wdata = 32'hFFFFFFFF; mem_write = 1'b0;
    @(posedge clk);
    #1;
    push_read(11'd0, 32'hA5A5A5A5);
    #1;
    exp = sb.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL write_disable got=%h exp=%h", rdata, exp);
    end
  endtask

  task automatic test_back_to_back();
    dm_word_t exp;
    @(negedge clk);
    addr = 11'd5; wdata = 32'h1; mem_write = 1'b1;
    @(negedge clk);
    wdata = 32'h2;
    @(posedge clk);
    model[5] = 32'h2;
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    push_read(11'd5, 32'h2);
    #1;
    exp = sb.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL back_to_back got=%h exp=%h", rdata, exp);
    end
  endtask

  task automatic test_read_during_write();
    dm_word_t exp;
    @(negedge clk);
    addr = 11'd1; wdata = 32'hCAFEF00D; mem_write = 1'b1;
    sb.push_back(model[1]);
    #1;
    exp = sb.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rdw_before got=%h exp=%h", rdata, exp);
    end
    @(posedge clk);
    model[1] = 32'hCAFEF00D;
    #1;
    mem_write = 1'b0;
    sb.push_back(model[1]);
    exp = sb.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rdw_after got=%h exp=%h", rdata, exp);
    end
  endtask

  task automatic test_random_burst();
    dm_word_t exp;
    dm_addr_t a [8];
    for (int i = 0; i < 8; i++) begin
      a[i] = dm_addr_t'($urandom_range(0, DM_DEPTH - 1));
      do_write(a[i], dm_word_t'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      push_read(a[i], model[a[i]]);
      #1;
      exp = sb.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL burst addr=%0d got=%h exp=%h", a[i], rdata, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    dm_word_t exp;
    dm_addr_t list [3];
    @(negedge clk);
    addr = 11'd1027; wdata = 32'hBADC0DE5; mem_write = 1'b1;
    #2;
    rst = 1'b1;
    clear_model();
    sb.push_back(32'h0);
    #1;
    exp = sb.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL async_reset_now got=%h exp=%h", rdata, exp);
    end
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    rst = 1'b0;
    list = '{11'd1027, 11'd0, 11'd2047};
    foreach (list[i]) begin
      @(negedge clk);
      push_read(list[i], model[list[i]]);
      #1;
      exp = sb.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL async_reset_after addr=%0d got=%h exp=%h", list[i], rdata, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_low();
    test_high_addr();
    test_write_disable();
    test_back_to_back();
    test_read_during_write();
    test_random_burst();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_memory

`default_nettype wire
